pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage MIPS core. It merges stall requests from ID (load-use), EX (multi-cycle mult/div) and MEM (bus wait) with MEM-stage exceptions. It drives the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, along with flush and redirect PC. It owns the multi-cycle EX countdown and a MEM bus-wait watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/pipe_ctrl_if.sv | 37 +++
 rtl/pipe_ctrl_bus_watchdog.sv | 42 ++++
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline controller: stall vectors,
// controller FSM states and the zero word used for idle redirect targets.
package pipe_ctrl_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  stall_t;

  // Bit order: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved
  localparam stall_t StallNone = 6'b000000;
  localparam stall_t StallId   = 6'b000111;
  localparam stall_t StallEx   = 6'b001111;
  localparam stall_t StallMem  = 6'b011111;

  localparam word_t ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    CtrlRun    = 2'b00,
    CtrlExwait = 2'b01,
    CtrlExdone = 2'b10
  } ctrl_state_e;

  // Highest-priority-first merge of the per-stage stall requests.
  function automatic stall_t merge_stall(input logic excp, input logic mem,
                                         input logic ex, input logic id);
    if (excp) begin
      return StallNone;
    end else if (mem) begin
      return StallMem;
    end else if (ex) begin
      return StallEx;
    end else if (id) begin
      return StallId;
    end
    return StallNone;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
// The pipeline side is the master; the controller is the slave.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 6
);

  // Requests from the pipeline stages
  logic             stallreq_id;
  logic             ex_multi_start;
  logic [CNT_W-1:0] ex_multi_cycles;
  logic             stallreq_mem;
  logic             excp_valid;
  word_t            excp_vector;

  // Control back to the pipeline registers
  stall_t           stall;
  logic             flush;
  word_t            new_pc;
  logic             ex_done;
  logic             ex_abort;
  logic             bus_err;

  modport master (
    output stallreq_id, ex_multi_start, ex_multi_cycles, stallreq_mem,
           excp_valid, excp_vector,
    input  stall, flush, new_pc, ex_done, ex_abort, bus_err
  );

  modport slave (
    input  stallreq_id, ex_multi_start, ex_multi_cycles, stallreq_mem,
           excp_valid, excp_vector,
    output stall, flush, new_pc, ex_done, ex_abort, bus_err
  );

endinterface

// File: rtl/pipe_ctrl_bus_watchdog.sv
// Counts consecutive MEM bus-wait cycles and pulses bus_err each time the
// run reaches BUS_TIMEOUT cycles. BUS_TIMEOUT of 0 disables it entirely.
module pipe_ctrl_bus_watchdog #(
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8    // must be wide enough for BUS_TIMEOUT-1
) (
  input  logic clk,
  input  logic rst,
  input  logic stallreq_mem,
  input  logic clr,
  output logic bus_err
);

  localparam bit              Enabled = (BUS_TIMEOUT != 0);
  localparam int unsigned     LastCnt = Enabled ? (BUS_TIMEOUT - 1) : 0;
  localparam logic [TO_W-1:0] LastVal = TO_W'(LastCnt);

  logic [TO_W-1:0] to_cnt_q;
  logic            counting;

  assign counting = stallreq_mem && !clr;

  always_comb begin
    bus_err = 1'b0;
    if (Enabled && !rst && counting && (to_cnt_q == LastVal)) begin
      bus_err = 1'b1;
    end
  end

  // The stall is not released on expiry; the count restarts so a bus that
  // stays stuck keeps reporting every BUS_TIMEOUT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (!Enabled || !counting || bus_err) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges ID/EX/MEM stall requests with MEM
// exceptions, sequences multi-cycle EX ops and hosts the bus watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  ctrl
);

  ctrl_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;

  logic             ex_stall;
  logic             ex_done_raw;
  logic             ex_abort_raw;
  logic             wd_err;
  stall_t           stall_vec;
  logic             n_is_zero;
  logic             n_is_one;

  assign n_is_zero = (ctrl.ex_multi_cycles == '0);
  assign n_is_one  = (ctrl.ex_multi_cycles == CNT_W'(1));

  // EX-side request decode from the current state and the EX inputs.
  always_comb begin
    ex_stall     = 1'b0;
    ex_done_raw  = 1'b0;
    ex_abort_raw = 1'b0;
    unique case (state_q)
      CtrlRun: begin
        if (ctrl.ex_multi_start) begin
          ex_stall    = !n_is_zero;
          ex_done_raw = n_is_zero || n_is_one;
        end
      end
      CtrlExwait: begin
        ex_stall    = 1'b1;
        ex_done_raw = (cnt_q == CNT_W'(1));
      end
      CtrlExdone: begin
        // Finished op still sits in EX; a fresh start here is the same instruction.
        ex_stall    = 1'b0;
        ex_done_raw = 1'b0;
      end
      default: begin
        ex_stall    = 1'b0;
        ex_done_raw = 1'b0;
      end
    endcase
    if (ctrl.excp_valid) begin
      ex_done_raw  = 1'b0;
      ex_abort_raw = (state_q == CtrlExwait) ||
                     ((state_q == CtrlRun) && ctrl.ex_multi_start);
    end
  end

  assign stall_vec = merge_stall(ctrl.excp_valid, ctrl.stallreq_mem, ex_stall,
                                 ctrl.stallreq_id);

  always_comb begin
    ctrl.stall    = StallNone;
    ctrl.flush    = 1'b0;
    ctrl.new_pc   = ZeroWord;
    ctrl.ex_done  = 1'b0;
    ctrl.ex_abort = 1'b0;
    ctrl.bus_err  = 1'b0;
    if (!rst) begin
      ctrl.stall    = stall_vec;
      ctrl.flush    = ctrl.excp_valid;
      ctrl.new_pc   = ctrl.excp_valid ? ctrl.excp_vector : ZeroWord;
      ctrl.ex_done  = ex_done_raw;
      ctrl.ex_abort = ex_abort_raw;
      ctrl.bus_err  = wd_err;
    end
  end

  // Multi-cycle EX sequencer. cnt_q holds the stall cycles left after the
  // current one, so an N-cycle op stalls exactly N cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CtrlRun;
      cnt_q   <= '0;
    end else if (ctrl.excp_valid) begin
      state_q <= CtrlRun;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        CtrlRun: begin
          if (ctrl.ex_multi_start) begin
            if (n_is_zero) begin
              state_q <= CtrlExdone;
              cnt_q   <= '0;
            end else begin
              state_q <= n_is_one ? CtrlExdone : CtrlExwait;
              cnt_q   <= ctrl.ex_multi_cycles - 1'b1;
            end
          end
        end
        CtrlExwait: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= CtrlExdone;
          end
        end
        CtrlExdone: begin
          // A new instruction enters EX once ID/EX is no longer held.
          if (!stall_vec[2]) begin
            state_q <= CtrlRun;
          end
        end
        default: begin
          state_q <= CtrlRun;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  pipe_ctrl_bus_watchdog #(
    .BUS_TIMEOUT (BUS_TIMEOUT),
    .TO_W        (TO_W)
  ) u_bus_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stallreq_mem (ctrl.stallreq_mem),
    .clr          (ctrl.excp_valid),
    .bus_err      (wd_err)
  );

  reserved_stall_bit_zero: assert property (@(posedge clk) !ctrl.stall[5]);
  done_abort_exclusive: assert property (@(posedge clk) !(ctrl.ex_done && ctrl.ex_abort));
  flush_has_no_stall: assert property (@(posedge clk) ctrl.flush |-> (ctrl.stall == StallNone));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized scoreboard bench for pipe_ctrl: a driver applies inputs and
// queues expected outputs from a cycle-count model; a monitor checks them.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        ex_done;
    logic        ex_abort;
    logic        bus_err;
    logic        bus_err_off;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        d_id    = 1'b0;
  logic        d_start = 1'b0;
  logic [5:0]  d_n     = '0;
  logic        d_mem   = 1'b0;
  logic        d_excp  = 1'b0;
  logic [31:0] d_vec   = '0;

  pipe_ctrl_if #(.CNT_W(6)) bus_a ();
  pipe_ctrl_if #(.CNT_W(6)) bus_b ();

  assign bus_a.stallreq_id     = d_id;
  assign bus_a.ex_multi_start  = d_start;
  assign bus_a.ex_multi_cycles = d_n;
  assign bus_a.stallreq_mem    = d_mem;
  assign bus_a.excp_valid      = d_excp;
  assign bus_a.excp_vector     = d_vec;
  assign bus_b.stallreq_id     = d_id;
  assign bus_b.ex_multi_start  = d_start;
  assign bus_b.ex_multi_cycles = d_n;
  assign bus_b.stallreq_mem    = d_mem;
  assign bus_b.excp_valid      = d_excp;
  assign bus_b.excp_vector     = d_vec;

  pipe_ctrl #(.CNT_W(6), .BUS_TIMEOUT(8), .TO_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus_a)
  );

  pipe_ctrl #(.CNT_W(6), .BUS_TIMEOUT(0), .TO_W(8)) dut_off (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus_b)
  );

  obs_t exp_q[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned cyc         = 0;

  // Reference state: stall cycles still owed by the current EX op, whether a
  // finished op still occupies EX, and the length of the current bus-wait run.
  int m_left   = 0;
  bit m_hold   = 1'b0;
  int m_streak = 0;

  task automatic step(input bit r, input bit id, input bit st, input logic [5:0] n,
                      input bit mem, input bit ex, input logic [31:0] vec);
    obs_t e;
    bit   fresh;
    bit   done_zero;
    bit   ex_stall;
    @(posedge clk);
    #1;
    rst = r; d_id = id; d_start = st; d_n = n; d_mem = mem; d_excp = ex; d_vec = vec;
    cyc++;
    e = '0;
    if (r) begin
      m_left = 0; m_hold = 1'b0; m_streak = 0;
    end else if (ex) begin
      e.flush    = 1'b1;
      e.new_pc   = vec;
      e.ex_abort = (m_left > 0) || (!m_hold && st);
      m_left = 0; m_hold = 1'b0; m_streak = 0;
    end else begin
      fresh     = !m_hold && (m_left == 0) && st;
      done_zero = fresh && (n == 6'd0);
      if (fresh) m_left = int'(n);
      ex_stall  = (m_left > 0);
      e.ex_done = done_zero || (m_left == 1);
      if (mem)           e.stall = 6'b011111;
      else if (ex_stall) e.stall = 6'b001111;
      else if (id)       e.stall = 6'b000111;
      if (mem) begin
        m_streak++;
        e.bus_err = (m_streak % 8 == 0);
      end else begin
        m_streak = 0;
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_hold = 1'b1;
      end else if (done_zero) begin
        m_hold = 1'b1;
      end else if (m_hold && !e.stall[2]) begin
        m_hold = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 6'd0, 0, 0, 32'h0);
  endtask

  obs_t got, want;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {bus_a.stall, bus_a.flush, bus_a.new_pc, bus_a.ex_done, bus_a.ex_abort,
              bus_a.bus_err, bus_b.bus_err};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: got stall=%b flush=%b new_pc=%h done=%b abort=%b bus_err=%b bus_err_off=%b; want stall=%b flush=%b new_pc=%h done=%b abort=%b bus_err=%b bus_err_off=%b",
                 cyc, got.stall, got.flush, got.new_pc, got.ex_done, got.ex_abort,
                 got.bus_err, got.bus_err_off, want.stall, want.flush, want.new_pc,
                 want.ex_done, want.ex_abort, want.bus_err, want.bus_err_off);
      end
    end
  end

  int unsigned burst;
  initial begin
    // Reset with every request raised
    for (int i = 0; i < 3; i++) step(1, 1, 1, 6'd4, 1, 1, 32'hDEAD_BEEF);
    step(0, 1, 0, 6'd0, 0, 0, 32'h0);
    idle(1);
    // N=4 with start held through the EXDONE cycle
    for (int i = 0; i < 5; i++) step(0, 0, 1, 6'd4, 0, 0, 32'h0);
    idle(2);
    // N=3 overlapped by a 5-cycle MEM stall
    step(0, 0, 1, 6'd3, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 6'd3, 1, 0, 32'h0);
    idle(2);
    // Exception aborts N=10, then a new op is accepted right away
    step(0, 0, 1, 6'd10, 0, 0, 32'h0);
    step(0, 0, 0, 6'd10, 0, 0, 32'h0);
    step(0, 0, 0, 6'd10, 0, 1, 32'hBFC0_0380);
    step(0, 0, 1, 6'd2, 0, 0, 32'h0);
    idle(3);
    // Edge lengths, with an ID request alongside the start
    step(0, 1, 1, 6'd1, 0, 0, 32'h0);
    idle(2);
    step(0, 1, 1, 6'd0, 0, 0, 32'h0);
    idle(2);
    // Watchdog: 20 stuck bus cycles
    for (int i = 0; i < 20; i++) step(0, 0, 0, 6'd0, 1, 0, 32'h0);
    idle(2);
    // Randomized traffic
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, id, st, mem, ex;
      logic [5:0] n;
      r  = ($urandom_range(0, 199) == 0);
      id = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 2) == 0);
      ex = ($urandom_range(0, 24) == 0);
      n  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 40)) : 6'($urandom_range(0, 6));
      if (burst == 0 && $urandom_range(0, 14) == 0) burst = $urandom_range(1, 20);
      mem = (burst != 0);
      if (burst != 0) burst--;
      step(r, id, st, n, mem, ex, $urandom());
    end
    idle(1);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
